li_sender: RTL and testbench

LI_SENDER -- requirements
Module: li_sender

---
 rtl/li_pkg.sv | 13 +
 rtl/li_ready_history.sv | 27 ++
 rtl/li_sender.sv | 95 +++++++++
 tb/tb_li_sender.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/li_pkg.sv
// rtl/li_pkg.sv - shared types and helpers for the latency-insensitive sender
package li_pkg;

  localparam int STALL_CNT_W = 32;

  typedef logic [STALL_CNT_W-1:0] stall_cnt_t;

  // Buffer depth from address bits without relying on $clog2.
  function automatic int depth_of(input int addr);
    return 1 << addr;
  endfunction

endpackage

// File: rtl/li_ready_history.sv
// rtl/li_ready_history.sv - LATENCY-deep delay line of link ready; permit is ready from LATENCY cycles ago
module li_ready_history #(
  parameter int LATENCY = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic i_ready,
  output logic permit
);

  logic [LATENCY-1:0] hist;

  if (LATENCY == 1) begin : g_one
    always_ff @(posedge clock) begin
      if (reset) hist <= '0;
      else       hist <= i_ready;
    end
  end else begin : g_many
    always_ff @(posedge clock) begin
      if (reset) hist <= '0;
      else       hist <= {hist[LATENCY-2:0], i_ready};
    end
  end

  assign permit = hist[LATENCY-1];

endmodule

// File: rtl/li_sender.sv
// rtl/li_sender.sv - show-ahead buffered sender onto a ready-latency link
// Optional stall counter built when LI_SENDER_STALL_CNT_EN is defined.
module li_sender
  import li_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_ADDR     = 2,
  parameter int READY_LATENCY = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [DATA_WIDTH-1:0]  o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [STALL_CNT_W-1:0] o_stall_count
);

  if (READY_LATENCY < 1) begin : g_bad_latency
    $error("li_sender: READY_LATENCY must be >= 1");
  end
  if (FIFO_ADDR < 1) begin : g_bad_addr
    $error("li_sender: FIFO_ADDR must be >= 1");
  end
  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("li_sender: DATA_WIDTH must be >= 1");
  end

  localparam int             DEPTH   = depth_of(FIFO_ADDR);
  localparam logic [FIFO_ADDR:0] DEPTH_C = (FIFO_ADDR+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [FIFO_ADDR-1:0]  head;
  logic [FIFO_ADDR-1:0]  tail;
  logic [FIFO_ADDR:0]    count;
  logic                  permit;
  logic                  enq;
  logic                  deq;

  li_ready_history #(
    .LATENCY (READY_LATENCY)
  ) u_ready_history (
    .clock   (clock),
    .reset   (reset),
    .i_ready (i_ready),
    .permit  (permit)
  );

  // Both handshakes come from registered state, so nothing bypasses i_valid to o_valid.
  assign o_ready = (count < DEPTH_C);
  assign o_valid = permit && (count != '0);
  assign o_data  = mem[head];

  assign enq = i_valid && o_ready;
  assign deq = o_valid;

  always_ff @(posedge clock) begin
    if (enq) mem[tail] <= i_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef LI_SENDER_STALL_CNT_EN
  stall_cnt_t stall_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= '0;
    end else if ((count != '0) && !permit && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign o_stall_count = stall_q;
`else
  assign o_stall_count = '0;
`endif

endmodule

// File: tb/tb_li_sender.sv
// tb/tb_li_sender.sv - directed self-checking bench for li_sender (DATA_WIDTH=8, FIFO_ADDR=2, READY_LATENCY=2)
module tb_li_sender;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  i_data = 8'h00;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  li_sender #(
    .DATA_WIDTH    (8),
    .FIFO_ADDR     (2),
    .READY_LATENCY (2)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .i_data        (i_data),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_stall_count (o_stall_count)
  );

  always #5 clock = ~clock;

  // Expected stall count: the counter only exists when the feature is built.
  function automatic logic [31:0] stall_exp(input int n);
`ifdef LI_SENDER_STALL_CNT_EN
    return 32'(n);
`else
    return 32'd0 + 32'(n - n);
`endif
  endfunction

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", o_valid); end
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%0b exp=1", o_ready); end
    n_checks++; if (o_stall_count !== 32'd0) begin n_fail++; $display("FAIL reset_stall got=%0d exp=0", o_stall_count); end
  endtask

  task automatic test_basic();
    i_ready = 1'b1;
    tick(); tick();
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL basic_empty_valid got=%0b exp=0", o_valid); end
    i_valid = 1'b1; i_data = 8'h11;
    tick();
    i_valid = 1'b0;
    n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%0b exp=1", o_valid); end
    n_checks++; if (o_data !== 8'h11) begin n_fail++; $display("FAIL basic_data got=%h exp=11", o_data); end
    tick();
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL basic_single got=%0b exp=0", o_valid); end
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready got=%0b exp=1", o_ready); end
    n_checks++; if (o_stall_count !== stall_exp(0)) begin n_fail++; $display("FAIL basic_stall got=%0d exp=%0d", o_stall_count, stall_exp(0)); end
  endtask

  // Leaves A0..A3 buffered with stall count 4.
  task automatic test_backpressure(input int base);
    i_ready = 1'b0;
    tick(); tick(); tick();
    for (int k = 0; k < 4; k++) begin
      i_valid = 1'b1; i_data = 8'hA0 + 8'(k);
      tick();
      n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid[%0d] got=%0b exp=0", k, o_valid); end
      n_checks++; if (o_ready !== (k < 3)) begin n_fail++; $display("FAIL bp_ready[%0d] got=%0b exp=%0b", k, o_ready, k < 3); end
      n_checks++; if (o_stall_count !== stall_exp(base + k)) begin n_fail++; $display("FAIL bp_stall[%0d] got=%0d exp=%0d", k, o_stall_count, stall_exp(base + k)); end
    end
    i_data = 8'hA4;
    tick();
    i_valid = 1'b0;
    n_checks++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got=%0b exp=0", o_ready); end
    n_checks++; if (o_stall_count !== stall_exp(base + 4)) begin n_fail++; $display("FAIL bp_full_stall got=%0d exp=%0d", o_stall_count, stall_exp(base + 4)); end
  endtask

  task automatic test_ready_latency();
    logic [7:0] exp_d [4];
    exp_d[0] = 8'hA0; exp_d[1] = 8'hA1; exp_d[2] = 8'hA2; exp_d[3] = 8'hA3;
    i_ready = 1'b1;
    tick();
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rl_t1_valid got=%0b exp=0", o_valid); end
    tick();
    n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL rl_t2_valid got=%0b exp=1", o_valid); end
    n_checks++; if (o_data !== exp_d[0]) begin n_fail++; $display("FAIL rl_t2_data got=%h exp=%h", o_data, exp_d[0]); end
    n_checks++; if (o_stall_count !== stall_exp(6)) begin n_fail++; $display("FAIL rl_t2_stall got=%0d exp=%0d", o_stall_count, stall_exp(6)); end
    i_ready = 1'b0;
    tick();
    n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL rl_u1_valid got=%0b exp=1", o_valid); end
    n_checks++; if (o_data !== exp_d[1]) begin n_fail++; $display("FAIL rl_u1_data got=%h exp=%h", o_data, exp_d[1]); end
    tick();
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rl_u2_valid got=%0b exp=0", o_valid); end
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL rl_u2_ready got=%0b exp=1", o_ready); end
    i_ready = 1'b1;
    tick();
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rl_v1_valid got=%0b exp=0", o_valid); end
    for (int k = 2; k < 4; k++) begin
      tick();
      n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL rl_drain_valid[%0d] got=%0b exp=1", k, o_valid); end
      n_checks++; if (o_data !== exp_d[k]) begin n_fail++; $display("FAIL rl_drain_data[%0d] got=%h exp=%h", k, o_data, exp_d[k]); end
    end
    n_checks++; if (o_stall_count !== stall_exp(8)) begin n_fail++; $display("FAIL rl_stall got=%0d exp=%0d", o_stall_count, stall_exp(8)); end
    tick();
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rl_empty_valid got=%0b exp=0", o_valid); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) begin
      i_valid = 1'b1; i_data = 8'h30 + 8'(k);
      tick();
      n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d] got=%0b exp=1", k, o_valid); end
      n_checks++; if (o_data !== 8'h30 + 8'(k)) begin n_fail++; $display("FAIL b2b_data[%0d] got=%h exp=%h", k, o_data, 8'h30 + 8'(k)); end
      n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d] got=%0b exp=1", k, o_ready); end
    end
    i_valid = 1'b0;
    tick();
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end_valid got=%0b exp=0", o_valid); end
    n_checks++; if (o_stall_count !== stall_exp(8)) begin n_fail++; $display("FAIL b2b_stall got=%0d exp=%0d", o_stall_count, stall_exp(8)); end
  endtask

  task automatic test_reset_midstream();
    i_ready = 1'b0;
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1; i_data = 8'h40 + 8'(k);
      tick();
    end
    i_valid = 1'b0;
    n_checks++; if (o_stall_count !== stall_exp(10)) begin n_fail++; $display("FAIL rst_pre_stall got=%0d exp=%0d", o_stall_count, stall_exp(10)); end
    reset = 1'b1; i_ready = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%0b exp=0", o_valid); end
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got=%0b exp=1", o_ready); end
    n_checks++; if (o_stall_count !== 32'd0) begin n_fail++; $display("FAIL rst_stall got=%0d exp=0", o_stall_count); end
    i_valid = 1'b1; i_data = 8'h5A;
    tick();
    i_valid = 1'b0;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_r1_valid got=%0b exp=0", o_valid); end
    tick();
    n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL rst_r2_valid got=%0b exp=1", o_valid); end
    n_checks++; if (o_data !== 8'h5A) begin n_fail++; $display("FAIL rst_r2_data got=%h exp=5a", o_data); end
    n_checks++; if (o_stall_count !== stall_exp(1)) begin n_fail++; $display("FAIL rst_r2_stall got=%0d exp=%0d", o_stall_count, stall_exp(1)); end
    tick();
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_r3_valid got=%0b exp=0", o_valid); end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_basic();
    test_backpressure(0);
    test_ready_latency();
    test_back_to_back();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
